// File: rtl/apt_phase_gen.sv
// rtl/apt_phase_gen.sv - LRCK phase generator with delayed phase, APT strobes, lock and mute
//
// Samples LRCK on BCK, delays the sampled phase by DELAY BCK cycles and derives
// per-channel aperture strobes. Half-frame lengths are measured to assert lock;
// apertures only open while locked and only change mute state at a left-start.
//
// Ports:
//   bck        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   lrck       in   frame sync from the source
//   mute       in   level request to close both apertures
//   apt_l      out  left aperture strobe
//   apt_r      out  right aperture strobe
//   lrck_dly   out  delayed LRCK phase
//   lrck_dly_n out  inverse of lrck_dly
//   locked     out  frame timing valid
//   err        out  one-cycle pulse per framing fault

module apt_phase_gen #(
    parameter int BCK_PER_FRAME = 32,
    parameter int DELAY         = 8,
    parameter int LOCK_HALVES   = 4,
    parameter int LRCK_L_LEVEL  = 0
) (
    input  logic bck,
    input  logic rst_n,
    input  logic lrck,
    input  logic mute,
    output logic apt_l,
    output logic apt_r,
    output logic lrck_dly,
    output logic lrck_dly_n,
    output logic locked,
    output logic err
);

    localparam int HALF = BCK_PER_FRAME / 2;
    localparam int CW   = $clog2(BCK_PER_FRAME) + 1;
    localparam int GW   = $clog2(LOCK_HALVES + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(BCK_PER_FRAME - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(BCK_PER_FRAME - 2);
    localparam logic [CW-1:0] CNT_GOOD = CW'(HALF - 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_HALVES);
    localparam logic          L_LVL    = LRCK_L_LEVEL[0];

    logic             lrck_s;
    logic             lrck_p;
    logic [DELAY-1:0] d;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    good;
    logic             armed;
    logic             gate;

    logic             lrck_edge;
    logic             left_start;
    logic             timeout;
    logic             fault;
    logic [CW-1:0]    cnt_next;
    logic [GW-1:0]    good_next;
    logic [GW:0]      good_inc;
    logic             armed_next;
    logic             locked_next;
    logic             gate_next;
    logic             apt_l_next;
    logic             apt_r_next;

    assign lrck_dly   = d[DELAY-1];
    assign lrck_dly_n = ~d[DELAY-1];

    always_comb begin
        lrck_edge   = (lrck_s != lrck_p);
        left_start  = lrck_edge & (lrck_s == L_LVL);
        // Timeout fires only on the transition into saturation, so a stuck
        // LRCK produces exactly one err pulse.
        timeout     = ~lrck_edge & (cnt == CNT_PRE);
        good_inc    = {1'b0, good} + 1'b1;
        cnt_next    = cnt;
        good_next   = good;
        armed_next  = armed;
        locked_next = locked;
        fault       = 1'b0;

        if (lrck_edge) begin
            cnt_next = '0;
            if (!armed) begin
                // The first edge only starts a measurement.
                armed_next = 1'b1;
            end else if (cnt == CNT_GOOD) begin
                if (good_inc >= {1'b0, GOOD_MAX}) begin
                    good_next   = GOOD_MAX;
                    locked_next = 1'b1;
                end else begin
                    good_next = good_inc[GW-1:0];
                end
            end else begin
                good_next   = '0;
                locked_next = 1'b0;
                fault       = 1'b1;
            end
        end else begin
            if (cnt != CNT_MAX) begin
                cnt_next = cnt + 1'b1;
            end
            if (timeout) begin
                good_next   = '0;
                locked_next = 1'b0;
                armed_next  = 1'b0;
                fault       = 1'b1;
            end
        end

        // Loss of lock closes the gate at once; mute changes wait for a left-start.
        if (!locked_next) begin
            gate_next = 1'b0;
        end else if (left_start) begin
            gate_next = ~mute;
        end else begin
            gate_next = gate;
        end

        apt_l_next = gate_next & (lrck_s == L_LVL) & (lrck_dly == L_LVL);
        apt_r_next = gate_next & (lrck_s != L_LVL) & (lrck_dly != L_LVL);
    end

    always_ff @(posedge bck or negedge rst_n) begin
        if (!rst_n) begin
            lrck_s <= 1'b0;
            lrck_p <= 1'b0;
            d      <= '0;
            cnt    <= '0;
            good   <= '0;
            armed  <= 1'b0;
            locked <= 1'b0;
            gate   <= 1'b0;
            apt_l  <= 1'b0;
            apt_r  <= 1'b0;
            err    <= 1'b0;
        end else begin
            lrck_s <= lrck;
            lrck_p <= lrck_s;
            d[0]   <= lrck_s;
            for (int i = 1; i < DELAY; i++) begin
                d[i] <= d[i-1];
            end
            cnt    <= cnt_next;
            good   <= good_next;
            armed  <= armed_next;
            locked <= locked_next;
            gate   <= gate_next;
            apt_l  <= apt_l_next;
            apt_r  <= apt_r_next;
            err    <= fault;
        end
    end

endmodule

// File: doc/apt_phase_gen.md
Name: apt_phase_gen

Overview:
- Parametrised successor to the 701ES APT/HC74 phase generator for the LJ audio output path.
- Samples LRCK on BCK and produces a delayed LRCK phase (true and inverted) with a programmable BCK delay.
- Produces per-channel APT (deglitch aperture) strobes from the sampled and delayed LRCK phases.
- Adds frame-length lock detection, error flagging, and mute that takes effect only on frame boundaries, so APT strobes never glitch on a bad or stopped clock.

Parameters:
- BCK_PER_FRAME, 32, BCK cycles per LRCK frame; must be even, ≥8 (32/48/64 in use); HALF = BCK_PER_FRAME/2.
- DELAY, 8, BCK delay stages for the delayed phase; legal range 1..HALF-1.
- LOCK_HALVES, 4, consecutive correct half-frames required to assert lock; ≥1.
- LRCK_L_LEVEL, 0, LRCK level that denotes the left channel.

Ports:
- bck  in  1  sole clock; every register updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lrck  in  1  frame sync from the source.
- mute  in  1  level request to close both apertures.
- apt_l  out  1  left aperture strobe.
- apt_r  out  1  right aperture strobe.
- lrck_dly  out  1  delayed LRCK phase (HC74 Q equivalent).
- lrck_dly_n  out  1  inverse of lrck_dly.
- locked  out  1  frame timing valid.
- err  out  1  one-cycle pulse on each framing fault.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0, except lrck_dly_n = 1.
  - All internal state cleared: delay chain 0, counters 0, gate 0, measurement-armed flag 0.
- Sampling:
  - lrck_s <= lrck.
  - lrck_p <= lrck_s.
  - An edge occurs in any cycle where lrck_s != lrck_p.
- Delay chain:
  - d[0] <= lrck_s; d[i] <= d[i-1].
  - lrck_dly = d[DELAY-1], so an LRCK pin change appears on lrck_dly DELAY+1 rising edges after it is sampled.
  - lrck_dly_n = ~lrck_dly at all times, including reset.
- Half-frame counter cnt:
  - Width clog2(BCK_PER_FRAME)+1.
  - Clears to 0 on an edge cycle.
  - Otherwise increments, saturating at BCK_PER_FRAME-1.
- Lock checking on an edge (cnt evaluated before it clears):
  - If not armed: set armed and make no judgement. This covers the first edge after reset and the first edge after a timeout.
  - If armed and cnt == HALF-1: good <= min(good+1, LOCK_HALVES); locked <= 1 when good+1 ≥ LOCK_HALVES.
  - If armed and cnt != HALF-1: good <= 0; locked <= 0; err = 1 for one cycle.
- Timeout:
  - Triggers in the cycle cnt becomes BCK_PER_FRAME-1 with no edge.
  - Effect: locked <= 0, good <= 0, armed <= 0, err = 1 for one cycle.
  - While stuck, the counter is saturated and err does not repeat.
- Gate register:
  - Left-start = an edge cycle where lrck_s == LRCK_L_LEVEL. At left-start, gate <= locked_next & ~mute.
  - If locked_next is 0 in any cycle, gate <= 0 immediately, without waiting for left-start.
  - A mute assertion or deassertion mid-frame takes effect at the next left-start only.
  - When lock is first gained on a non-left edge, the gate opens at the following left-start.
- Aperture strobes (registered):
  - apt_l <= gate_next & (lrck_s == LRCK_L_LEVEL) & (lrck_dly == LRCK_L_LEVEL).
  - apt_r <= gate_next & (lrck_s != LRCK_L_LEVEL) & (lrck_dly != LRCK_L_LEVEL).
  - apt_l and apt_r are never both 1.
  - Each strobe is high HALF-DELAY cycles per half-frame in steady state.
- Simultaneous events:
  - A fault and left-start in the same cycle: the fault wins, and gate stays 0.
  - Timeout cannot coincide with an edge; an edge clears cnt first.

Test Plan:
- Lock and steady state (defaults, clean 32-BCK frames, LRCK low first): locked rises at the 5th edge, i.e. first edge arms, then 4 good halves. Gate opens at the next left-start. Then per frame: apt_l high 8 cycles, apt_r high 8 cycles, lrck_dly lags lrck by 9 BCK, lrck_dly_n is the exact inverse.
- Short half (after lock, one half of 15 BCK): at that edge, err pulses once, and locked, apt_l, and apt_r drop within 1 cycle. Relock needs 4 further good halves, with apertures reopening at the next left-start.
- Stuck LRCK (after lock, hold lrck constant): err pulses once when cnt reaches 31, locked goes 0, and there is no further err. On restart, the first edge only arms and lock returns after 4 more good halves.
- Mute mid-left-half: apt_l completes its current window. From the next left-start, apt_l and apt_r stay 0. Releasing mute mid-right-half reopens the apertures only at the following left-start.
- Reset mid-operation (rst_n low during an apt_l window): all outputs go 0 asynchronously, with lrck_dly_n = 1. After release, full reacquisition is required: arm plus 4 good halves.
- Variant BCK_PER_FRAME=64, DELAY=3, LRCK_L_LEVEL=1: apt_l is high 29 cycles while lrck is high; a 33-BCK half flags err.
